// File: rtl/dma_priority_arb_pkg.sv
// Shared types and constants for the DMA request/priority stage.
// Optional feature macro: DMA_SW_REQ_EN (software request path).
package dma_priority_arb_pkg;

  localparam int NUM_DMA_CH = 4;

  // Polarity select values for the command register sense bits
  localparam logic DREQ_HIGH = 1'b0;
  localparam logic DREQ_LOW  = 1'b1;
  localparam logic DACK_LOW  = 1'b0;
  localparam logic DACK_HIGH = 1'b1;

  typedef enum logic [1:0] {
    CH0_SEL = 2'd0,
    CH1_SEL = 2'd1,
    CH2_SEL = 2'd2,
    CH3_SEL = 2'd3
  } CHANNEL_SELECT_e;

  // Arbiter states kept as plain constants so legacy code can compare raw codes
  typedef logic [1:0] ARB_STATE_e;
  localparam ARB_STATE_e A_IDLE  = 2'd0;
  localparam ARB_STATE_e A_REQ   = 2'd1;
  localparam ARB_STATE_e A_GRANT = 2'd2;

  // Search from 'start' upward with wrap 3->0; first set request wins.
  // Walking the offsets from the far end lets the nearest hit overwrite.
  function automatic logic [1:0] pick_winner(input logic [NUM_DMA_CH-1:0] req,
                                             input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = start;
    for (int k = NUM_DMA_CH - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dma_priority_arb_req_sync.sv
// Multi-stage synchronizer for the asynchronous DREQ pins.
module dma_req_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  // Shift each pin through the flop chain; cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/dma_priority_arb.sv
// DMA request conditioning, priority resolution and HRQ/HLDA handshake.
// Delivers a frozen channel select and DACK to the timing FSM per service.
// Optional feature macro: DMA_SW_REQ_EN (include sw_req in the request set).
//
// state   | meaning
// A_IDLE  | no service pending; raise hrq when an enabled request appears
// A_REQ   | hrq high, winner tracked every cycle, waiting for hlda
// A_GRANT | channel frozen, dack active, waiting for svc_done or hlda loss
module dma_priority_arb
  import dma_priority_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              cmd_dreq_sense,
  input  logic              cmd_dack_sense,
  input  logic              cmd_rot_pri,
  input  logic              cmd_ctrl_dis,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              hlda,
  input  logic              svc_done,
  output logic              hrq,
  output logic [1:0]        ch_sel,
  output logic              ch_valid,
  output logic [NUM_CH-1:0] dack
);

  logic [NUM_CH-1:0] sync_dreq;
  logic [NUM_CH-1:0] hw_req;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] dack_int;
  ARB_STATE_e        state;
  logic [1:0]        ptr;
  logic [1:0]        winner;
  CHANNEL_SELECT_e   sel_q;

  dma_req_sync #(
    .WIDTH      (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (dreq),
    .q      (sync_dreq)
  );

  assign hw_req = (sync_dreq ^ {NUM_CH{cmd_dreq_sense}}) & ~mask;

`ifdef DMA_SW_REQ_EN
  // Software requests skip both the mask and the synchronizer
  assign eff = hw_req | sw_req;
`else
  logic unused_sw_req;
  assign unused_sw_req = ^sw_req;
  assign eff = hw_req;
`endif

  // Fixed mode always searches from channel 0
  assign winner = pick_winner(eff, cmd_rot_pri ? ptr : 2'd0);

  // Arbitration handshake and grant freeze
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= A_IDLE;
      hrq      <= 1'b0;
      ch_valid <= 1'b0;
      sel_q    <= CH0_SEL;
      dack_int <= '0;
      ptr      <= 2'd0;
    end else begin
      case (state)
        A_IDLE: begin
          // Also drops an hrq left high after svc_done once requests vanish
          hrq <= (|eff) && !cmd_ctrl_dis;
          if ((|eff) && !cmd_ctrl_dis) state <= A_REQ;
        end
        A_REQ: begin
          if (!(|eff)) begin
            hrq   <= 1'b0;
            state <= A_IDLE;
          end else if (hlda) begin
            sel_q    <= CHANNEL_SELECT_e'(winner);
            ch_valid <= 1'b1;
            dack_int <= NUM_CH'(1) << winner;
            state    <= A_GRANT;
          end
        end
        A_GRANT: begin
          // svc_done has precedence over a simultaneous hlda fall
          if (svc_done) begin
            ch_valid <= 1'b0;
            dack_int <= '0;
            hrq      <= (|eff) && !cmd_ctrl_dis;
            if (cmd_rot_pri) ptr <= sel_q + 2'd1;
            state    <= A_IDLE;
          end else if (!hlda) begin
            ch_valid <= 1'b0;
            dack_int <= '0;
            hrq      <= 1'b0;
            state    <= A_IDLE;
          end
        end
        default: begin
          state    <= A_IDLE;
          hrq      <= 1'b0;
          ch_valid <= 1'b0;
          dack_int <= '0;
        end
      endcase
    end
  end

  assign ch_sel = sel_q;
  assign dack   = dack_int ^ {NUM_CH{~cmd_dack_sense}};

endmodule

// File: doc/dma_priority_arb.md
Name: dma_priority_arb

Overview:
- Request/priority stage directly upstream of the DMA timing FSM (SI, S0–S4).
- Synchronizes and conditions the DREQ pins, applies mask and software requests, and resolves fixed or rotating priority.
- Runs the HRQ/HLDA handshake with the CPU and delivers a frozen channel select plus a DACK to the timing FSM for the whole service.
- Rotates priority when the FSM reports the service complete.

Parameters:
- NUM_CH, 4, number of DMA channels. Only 4 is supported; it matches the 2-bit channel select.
- SYNC_STAGES, 2, flop stages on each DREQ pin, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dreq  in  NUM_CH  raw DMA request pins
- cmd_dreq_sense  in  1  0: DREQ active high; 1: DREQ active low
- cmd_dack_sense  in  1  0: DACK active low; 1: DACK active high
- cmd_rot_pri  in  1  0: fixed priority (ch0 highest); 1: rotating priority
- cmd_ctrl_dis  in  1  controller disable; blocks new arbitration
- mask  in  NUM_CH  channel mask register, 1 = masked
- sw_req  in  NUM_CH  software request register bits
- hlda  in  1  hold acknowledge from the CPU
- svc_done  in  1  one-cycle pulse from the timing FSM when the granted service ends (TC, EOP, or end of a single transfer)
- hrq  out  1  hold request to the CPU
- ch_sel  out  2  granted channel, CHANNEL_SELECT_e encoding
- ch_valid  out  1  grant active; the timing FSM may leave SI
- dack  out  NUM_CH  DMA acknowledge pins, polarity per cmd_dack_sense

Behaviour:
- Reset values (async, reset_n low):
  - hrq=0, ch_valid=0, ch_sel=CH0_SEL.
  - Internal dack vector 0, so every pin drives its inactive level: dack = {NUM_CH{~cmd_dack_sense}}.
  - Priority pointer = 0 (ch0 highest).
  - Synchronizer flops cleared.
  - FSM in A_IDLE.
- Effective request:
  - eff[i] = ((sync_dreq[i] ^ cmd_dreq_sense) & ~mask[i]) | sw_req[i].
  - sw_req bypasses both the mask and the synchronizer.
- Priority:
  - Fixed mode: lowest index wins.
  - Rotating mode: the search starts at the pointer and wraps 3→0.
- FSM states and transitions:
  - A_IDLE: if (|eff && !cmd_ctrl_dis), go to A_REQ and set hrq=1 on that edge.
  - A_REQ:
    - Winner is re-evaluated every cycle.
    - If eff becomes 0, drop hrq and return to A_IDLE.
    - If hlda is sampled high, latch the winner into ch_sel, set ch_valid=1 and dack[ch_sel] active, and go to A_GRANT.
  - A_GRANT:
    - ch_sel and dack are frozen; later changes to dreq, mask or sw_req are ignored.
    - On svc_done: clear ch_valid and dack on the next edge and go to A_IDLE. In rotating mode the pointer becomes (ch_sel+1) mod 4. hrq stays high only if eff is still nonzero and the controller is enabled; otherwise hrq drops.
    - If hlda falls while in A_GRANT: abort to A_IDLE, clear hrq, ch_valid and dack, and leave the pointer unchanged.
- Latency:
  - dreq pin edge to hrq high: SYNC_STAGES+1 rising edges (3 by default).
  - sw_req to hrq: 1 edge.
  - hlda high to ch_valid/dack: 1 edge.
- Simultaneous events:
  - svc_done together with a hlda fall: treat as svc_done, so rotation happens.
  - cmd_ctrl_dis asserted in A_GRANT: the current service completes; no new request is raised.
- dack polarity is combinational: dack = dack_int ^ {NUM_CH{~cmd_dack_sense}}.
- Reset mid-service returns every output to its reset value immediately (asynchronous).

Optional Feature:
- Macro DMA_SW_REQ_EN.
- Defined: the sw_req path is included as described above.
- Undefined: sw_req is ignored, eff = synchronized, masked DREQ only, and the port remains present but unused.

Decomposition:
- DmaPackage gains:
  - ARB_STATE_e {A_IDLE, A_REQ, A_GRANT}.
  - Constant NUM_DMA_CH = 4.
  - Polarity constants DREQ_HIGH/DREQ_LOW and DACK_LOW/DACK_HIGH.
  - Reuse of CHANNEL_SELECT_e for ch_sel.
- One sub-module, dma_req_sync: the SYNC_STAGES-deep per-bit synchronizer, instanced once at NUM_CH width.

Test Plan:
- Fixed priority: dreq=4'b1010, sense 0, mask 0 → hrq on 3rd edge; after hlda, ch_sel=1 and dack=4'b1101 (active low).
- Rotating priority: service ch1 then pulse svc_done with dreq=4'b1011 held → next grant is ch3 (pointer 2); after that, ch0.
- Mask/sense: cmd_dreq_sense=1, dreq=4'b1110, mask=4'b0001 → no hrq; clearing the mask → hrq after 1 edge, grant ch0.
- Software request: dreq idle, sw_req=4'b0100, mask=4'b0100 → hrq next edge, grant ch2. With DMA_SW_REQ_EN undefined → hrq stays 0.
- Abort and disable: drop hlda mid-grant → ch_valid=0, dack inactive and pointer unchanged; with cmd_ctrl_dis=1 and a pending dreq → hrq stays 0.
- Asynchronous reset in A_GRANT: reset_n low → hrq=0, ch_valid=0 and dack=4'b1111 (sense 0) immediately, without waiting for a clock edge.
